// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch stage.
//               Defines the fetch FSM state type and the opcode field
//               position within an instruction word.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_IF1   = 3'd1,
        S_IF2   = 3'd2,
        S_VALID = 3'd3,
        S_HALT  = 3'd4
    } fetch_state_t;

    localparam logic [2:0] HALT_OP_DEFAULT = 3'b111;
    localparam int         OPCODE_MSB      = 15;
    localparam int         OPCODE_LSB      = 13;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : pc_reg
// Description : Program counter register. Asynchronously cleared, with a
//               load enable (takes load_val) and an increment enable that
//               wraps modulo 2^ADDR_W. Load has priority over increment.
// Ports       : clk, rst_n (async active-low clear), load, load_val[ADDR_W],
//               inc, pc[ADDR_W] (registered output)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_reg #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
        end else if (load) begin
            r_pc <= load_val;
        end else if (inc) begin
            // Natural overflow of the ADDR_W-bit sum gives the wrap to zero.
            r_pc <= r_pc + ADDR_W'(1);
        end
    end

    assign pc = r_pc;

endmodule : pc_reg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Holds PC and IR, loads start_pc
//               after reset, reads one RAM word per instruction and offers
//               it to the controller over a valid/ready handshake. Yields
//               the RAM port while the controller performs data accesses
//               and stops permanently once a HALT instruction is consumed.
// Ports       : clk, rst_n (async active-low), start_pc, dmem_busy,
//               mem_rdata, mem_rd, mem_addr, ir, ir_valid, ir_ready, pc,
//               halted; with BREAKPOINT_EN also bp_en, bp_addr.
// Config      : BREAKPOINT_EN - when defined, a fetch from bp_addr with
//               bp_en set halts instead of issuing the read.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int         ADDR_W  = 8,
    parameter int         DATA_W  = 16,
    parameter logic [2:0] HALT_OP = HALT_OP_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              dmem_busy,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [ADDR_W-1:0] pc,
`ifdef BREAKPOINT_EN
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
`endif
    output logic              halted
);

    fetch_state_t      r_state;
    fetch_state_t      w_next_state;
    logic [DATA_W-1:0] r_ir;
    logic [ADDR_W-1:0] w_pc;
    logic              w_pc_load;
    logic              w_pc_inc;
    logic              w_ir_load;
    logic              w_mem_rd;
    logic              w_bp_hit;
    logic              w_is_halt;

`ifdef BREAKPOINT_EN
    assign w_bp_hit = bp_en && (w_pc == bp_addr);
`else
    assign w_bp_hit = 1'b0;
`endif

    assign w_is_halt = (r_ir[OPCODE_MSB:OPCODE_LSB] == HALT_OP);

    pc_reg #(
        .ADDR_W (ADDR_W)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_pc_load),
        .load_val (start_pc),
        .inc      (w_pc_inc),
        .pc       (w_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pc_load    = 1'b0;
        w_pc_inc     = 1'b0;
        w_ir_load    = 1'b0;
        w_mem_rd     = 1'b0;
        case (r_state)
            S_RESET: begin
                w_pc_load    = 1'b1;
                w_next_state = S_IF1;
            end
            S_IF1: begin
                // Breakpoint outranks the data-access stall: no read is
                // ever issued from the breakpoint address.
                if (w_bp_hit) begin
                    w_next_state = S_HALT;
                end else if (!dmem_busy) begin
                    w_mem_rd     = 1'b1;
                    w_next_state = S_IF2;
                end
            end
            S_IF2: begin
                // RAM data for the read issued in S_IF1 is present now.
                w_ir_load    = 1'b1;
                w_pc_inc     = 1'b1;
                w_next_state = S_VALID;
            end
            S_VALID: begin
                if (ir_ready) begin
                    w_next_state = w_is_halt ? S_HALT : S_IF1;
                end
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_RESET;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir <= '0;
        end else if (w_ir_load) begin
            r_ir <= mem_rdata;
        end
    end

    assign mem_rd   = w_mem_rd;
    assign mem_addr = w_pc;
    assign pc       = w_pc;
    assign ir       = r_ir;
    assign ir_valid = (r_state == S_VALID);
    assign halted   = (r_state == S_HALT);

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A 256x16 RAM with a
//               one-cycle registered read sits on the fetch port. A
//               transaction-level model predicts the visible outputs and is
//               compared on every falling edge; directed sequences add
//               hand-computed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] start_pc;
    logic              dmem_busy;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] ir;
    logic              ir_valid;
    logic              ir_ready;
    logic [ADDR_W-1:0] pc;
    logic              halted;
`ifdef BREAKPOINT_EN
    logic              bp_en;
    logic [ADDR_W-1:0] bp_addr;
    logic              seen_rd6;
`endif

    logic [DATA_W-1:0] ram [256];

    int checks = 0;
    int errors = 0;
    bit running = 1'b1;

    fetch_unit #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .HALT_OP (3'b111)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_pc  (start_pc),
        .dmem_busy (dmem_busy),
        .mem_rdata (mem_rdata),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .pc        (pc),
`ifdef BREAKPOINT_EN
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
`endif
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model: "started" (PC loaded), a read in flight,
    // an instruction on offer, or stopped for good.
    // ------------------------------------------------------------------
    bit                m_started, m_inflight, m_valid, m_halted;
    logic [ADDR_W-1:0] m_pc;
    logic [DATA_W-1:0] m_ir;

    function automatic bit m_bp_hit();
`ifdef BREAKPOINT_EN
        return bp_en && (m_pc == bp_addr);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_want_fetch();
        return m_started && !m_inflight && !m_valid && !m_halted;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started = 0; m_inflight = 0; m_valid = 0; m_halted = 0;
            m_pc = '0; m_ir = '0;
        end else if (!m_started) begin
            m_started = 1;
            m_pc = start_pc;
        end else if (m_halted) begin
            // nothing moves once stopped
        end else if (m_inflight) begin
            m_ir = ram[m_pc];
            m_pc = m_pc + 8'd1;
            m_inflight = 0;
            m_valid = 1;
        end else if (m_valid) begin
            if (ir_ready) begin
                m_valid = 0;
                if (m_ir[15:13] == 3'b111) m_halted = 1;
            end
        end else if (m_bp_hit()) begin
            m_halted = 1;
        end else if (!dmem_busy) begin
            m_inflight = 1;
        end
    end

    always @(negedge clk) begin
        if (running) begin
            check("mdl_mem_rd", 32'(mem_rd), 32'(m_want_fetch() && !dmem_busy && !m_bp_hit()));
            check("mdl_mem_addr", 32'(mem_addr), 32'(m_pc));
            check("mdl_pc", 32'(pc), 32'(m_pc));
            check("mdl_ir", 32'(ir), 32'(m_ir));
            check("mdl_ir_valid", 32'(ir_valid), 32'(m_valid));
            check("mdl_halted", 32'(halted), 32'(m_halted));
        end
    end

`ifdef BREAKPOINT_EN
    always @(negedge clk) begin
        if (bp_en && mem_rd && mem_addr == 8'h06) seen_rd6 = 1'b1;
    end
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [ADDR_W-1:0] spc);
        step();
        rst_n = 1'b0;
        start_pc = spc;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'h0100 + 16'(i);
        ram[8'h04] = 16'hD0F0;
        ram[8'h05] = 16'h1234;
        ram[8'h10] = 16'hE000;
        ram[8'h19] = 16'h4019;
        ram[8'hFF] = 16'h2ABC;
        mem_rdata = '0;
`ifdef BREAKPOINT_EN
        bp_en = 1'b0; bp_addr = 8'h00; seen_rd6 = 1'b0;
`endif
        rst_n = 1'b0;
        start_pc = 8'h04;
        dmem_busy = 1'b0;
        ir_ready = 1'b0;

        // Reset state
        #3;
        check("rst_mem_rd", 32'(mem_rd), 32'h0);
        check("rst_ir_valid", 32'(ir_valid), 32'h0);
        check("rst_pc", 32'(pc), 32'h00);
        check("rst_ir", 32'(ir), 32'h0000);
        check("rst_halted", 32'(halted), 32'h0);

        // 1: first fetch from start_pc=04
        step(); step();
        rst_n = 1'b1;
        step();
        check("t1_rd", 32'(mem_rd), 32'h1);
        check("t1_addr", 32'(mem_addr), 32'h04);
        step();
        check("t1_if2_valid", 32'(ir_valid), 32'h0);
        check("t1_if2_rd", 32'(mem_rd), 32'h0);
        step();
        check("t1_valid", 32'(ir_valid), 32'h1);
        check("t1_ir", 32'(ir), 32'hD0F0);
        check("t1_pc", 32'(pc), 32'h05);

        // 2: controller stalls for 5 cycles
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_hold_valid", 32'(ir_valid), 32'h1);
            check("t2_hold_ir", 32'(ir), 32'hD0F0);
            check("t2_hold_pc", 32'(pc), 32'h05);
            check("t2_hold_rd", 32'(mem_rd), 32'h0);
        end
        ir_ready = 1'b1;
        step();
        check("t2_next_rd", 32'(mem_rd), 32'h1);
        check("t2_next_addr", 32'(mem_addr), 32'h05);

        // 3: data access holds off the fetch from pc=06
        step();
        step();
        check("t3_ir", 32'(ir), 32'h1234);
        dmem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_busy_rd", 32'(mem_rd), 32'h0);
            check("t3_busy_pc", 32'(pc), 32'h06);
        end
        dmem_busy = 1'b0;
        #1;
        check("t3_release_rd", 32'(mem_rd), 32'h1);
        check("t3_release_addr", 32'(mem_addr), 32'h06);

        // 6: asynchronous reset while in the second fetch cycle
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rd", 32'(mem_rd), 32'h0);
        check("t6_valid", 32'(ir_valid), 32'h0);
        check("t6_pc", 32'(pc), 32'h00);
        check("t6_ir", 32'(ir), 32'h0000);
        start_pc = 8'h19;
        step();
        rst_n = 1'b1;
        step();
        check("t6_restart_rd", 32'(mem_rd), 32'h1);
        check("t6_restart_addr", 32'(mem_addr), 32'h19);
        step(); step();
        check("t6_ir", 32'(ir), 32'h4019);
        repeat (12) step();

        // 5: PC wraps from FF to 00
        do_reset(8'hFF);
        step();
        check("t5_rd", 32'(mem_rd), 32'h1);
        check("t5_addr", 32'(mem_addr), 32'hFF);
        step(); step();
        check("t5_pc_wrap", 32'(pc), 32'h00);
        check("t5_ir", 32'(ir), 32'h2ABC);
        step();
        check("t5_next_addr", 32'(mem_addr), 32'h00);
        check("t5_next_rd", 32'(mem_rd), 32'h1);

        // 4: HALT instruction stops fetching for good
        do_reset(8'h10);
        repeat (4) step();
        for (int i = 0; i < 22; i++) begin
            dmem_busy = i[0];
            start_pc = 8'(i);
            step();
            check("t4_halted", 32'(halted), 32'h1);
            check("t4_valid", 32'(ir_valid), 32'h0);
            check("t4_rd", 32'(mem_rd), 32'h0);
            check("t4_pc", 32'(pc), 32'h11);
        end
        dmem_busy = 1'b0;

`ifdef BREAKPOINT_EN
        // 7: breakpoint at 06 after delivering 04 and 05
        bp_en = 1'b1;
        bp_addr = 8'h06;
        seen_rd6 = 1'b0;
        do_reset(8'h04);
        repeat (10) step();
        check("t7_halted", 32'(halted), 32'h1);
        check("t7_pc", 32'(pc), 32'h06);
        check("t7_ir", 32'(ir), 32'h1234);
        check("t7_no_read6", 32'(seen_rd6), 32'h0);
`endif

        running = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
